// File: rtl/fetch_frontend_pkg.sv
// Shared pipeline constants for the fetch front end.
//   INST_W           : instruction and PC width
//   NOP_INST         : bubble instruction, addi x0,x0,0
//   DEFAULT_RESET_PC : PC loaded on reset unless the top overrides it
//   PC_STEP          : sequential fetch increment
package fetch_frontend_pkg;
  localparam int               INST_W           = 32;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] PC_STEP          = 32'd4;
endpackage

// File: rtl/fetch_frontend_sat_counter.sv
// Saturating up-counter used for the debug performance counters.
// Ports:
//   clk   in          rising-edge clock
//   rst   in          asynchronous active-high reset, clears the count
//   inc   in          count one event on this edge
//   count out [W-1:0] current count; sticks at all-ones, never wraps
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = sat_inc(count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_frontend.sv
// Fetch front end of the 5-stage RISC-V pipeline: PC register, IF/ID
// register, taken-branch redirect/flush, and stall/flush counters.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   PCen        1 = PC advances, 0 = PC holds (load-use stall)
//   IF_IDen     1 = IF/ID loads, 0 = IF/ID holds
//   EX_PCSrc    taken branch/jump in EX; overrides both enables
//   EX_Target   redirect target (low two bits dropped)
//   IMem_Inst   instruction at IF_PC, sampled only on the clock edge
//   IF_PC       fetch address to IMem
//   ID_PC       PC of the instruction in ID
//   ID_Inst     instruction in ID (NOP_INST when bubbled)
//   ID_Valid    1 = ID holds a real fetched instruction
//   StallCount  saturating count of stall cycles without redirect
//   FlushCount  saturating count of redirect cycles
module fetch_frontend #(
  parameter logic [31:0] RESET_PC = fetch_frontend_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = fetch_frontend_pkg::NOP_INST,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCen,
  input  logic             IF_IDen,
  input  logic             EX_PCSrc,
  input  logic [31:0]      EX_Target,
  input  logic [31:0]      IMem_Inst,
  output logic [31:0]      IF_PC,
  output logic [31:0]      ID_PC,
  output logic [31:0]      ID_Inst,
  output logic             ID_Valid,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  import fetch_frontend_pkg::*;

  logic [INST_W-1:0] pc_p0_d;
  logic [INST_W-1:0] pc_p0_q;
  logic [INST_W-1:0] id_pc_p1_d;
  logic [INST_W-1:0] id_pc_p1_q;
  logic [INST_W-1:0] id_inst_p1_d;
  logic [INST_W-1:0] id_inst_p1_q;
  logic              vld_p1_d;
  logic              vld_p1_q;
  logic              stall_inc;
  logic              flush_inc;
  logic [1:0]        unused_tgt_lsb;

  // Redirect targets are word aligned; the low bits are intentionally dropped.
  assign unused_tgt_lsb = EX_Target[1:0];

  // IF stage: PC select, redirect first, then stall/advance
  always_comb begin
    pc_p0_d = pc_p0_q;
    if (EX_PCSrc) begin
      pc_p0_d = {EX_Target[31:2], 2'b00};
    end else if (PCen) begin
      pc_p0_d = pc_p0_q + PC_STEP;
    end
  end

  // IF/ID boundary: flush to a bubble on redirect, otherwise load or hold
  always_comb begin
    id_pc_p1_d   = id_pc_p1_q;
    id_inst_p1_d = id_inst_p1_q;
    vld_p1_d     = vld_p1_q;
    if (EX_PCSrc) begin
      id_pc_p1_d   = '0;
      id_inst_p1_d = NOP_INST;
      vld_p1_d     = 1'b0;
    end else if (IF_IDen) begin
      id_pc_p1_d   = pc_p0_q;
      id_inst_p1_d = IMem_Inst;
      vld_p1_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0_q      <= RESET_PC;
      id_pc_p1_q   <= '0;
      id_inst_p1_q <= NOP_INST;
      vld_p1_q     <= 1'b0;
    end else begin
      pc_p0_q      <= pc_p0_d;
      id_pc_p1_q   <= id_pc_p1_d;
      id_inst_p1_q <= id_inst_p1_d;
      vld_p1_q     <= vld_p1_d;
    end
  end

  // A stall that coincides with a redirect is counted only as a flush.
  assign stall_inc = ~EX_PCSrc & ~PCen;
  assign flush_inc = EX_PCSrc;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (StallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (FlushCount)
  );

  assign IF_PC    = pc_p0_q;
  assign ID_PC    = id_pc_p1_q;
  assign ID_Inst  = id_inst_p1_q;
  assign ID_Valid = vld_p1_q;

endmodule

// File: tb/tb_fetch_frontend.sv
// Scoreboard bench for fetch_frontend (CNT_W=4 so saturation is reachable).
module tb_fetch_frontend;

  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          pcen;
  logic          ifid_en;
  logic          pcsrc;
  logic [31:0]   target;
  logic [31:0]   imem;
  logic [31:0]   if_pc;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic          id_valid;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  typedef struct {
    logic [31:0] if_pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        vld;
    int          stall;
    int          flush;
  } exp_t;

  exp_t q[$];
  int   n_pass;
  int   n_total;

  fetch_frontend #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCen       (pcen),
    .IF_IDen    (ifid_en),
    .EX_PCSrc   (pcsrc),
    .EX_Target  (target),
    .IMem_Inst  (imem),
    .IF_PC      (if_pc),
    .ID_PC      (id_pc),
    .ID_Inst    (id_inst),
    .ID_Valid   (id_valid),
    .StallCount (stall_cnt),
    .FlushCount (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".IF_PC"},      if_pc,                 e.if_pc);
    chk({tag, ".ID_PC"},      id_pc,                 e.id_pc);
    chk({tag, ".ID_Inst"},    id_inst,               e.id_inst);
    chk({tag, ".ID_Valid"},   {31'd0, id_valid},     {31'd0, e.vld});
    chk({tag, ".StallCount"}, {{(32-CW){1'b0}}, stall_cnt}, e.stall);
    chk({tag, ".FlushCount"}, {{(32-CW){1'b0}}, flush_cnt}, e.flush);
  endtask

  // Drive one cycle's inputs at the current negedge, queue the state
  // expected after the following rising edge, then move to the next negedge.
  task automatic step(input logic pe, input logic ie, input logic src,
                      input logic [31:0] tgt, input logic [31:0] inst,
                      input logic [31:0] e_if, input logic [31:0] e_idpc,
                      input logic [31:0] e_inst, input logic e_vld,
                      input int e_stall, input int e_flush);
    exp_t e;
    pcen    = pe;
    ifid_en = ie;
    pcsrc   = src;
    target  = tgt;
    imem    = inst;
    e.if_pc   = e_if;
    e.id_pc   = e_idpc;
    e.id_inst = e_inst;
    e.vld     = e_vld;
    e.stall   = e_stall;
    e.flush   = e_flush;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the front end presents new state after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk_all("cyc", e);
      end
    end
  end

  initial begin
    exp_t r;
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    pcen    = 1'b1;
    ifid_en = 1'b1;
    pcsrc   = 1'b0;
    target  = 32'h0;
    imem    = 32'h00A0_0093;

    // Reset must act before any clock edge.
    #1 rst = 1'b1;
    #1;
    r.if_pc = 32'h0; r.id_pc = 32'h0; r.id_inst = NOP; r.vld = 1'b0;
    r.stall = 0; r.flush = 0;
    chk_all("rst0", r);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    //   PCen IF_IDen PCSrc Target        IMem           IF_PC         ID_PC         ID_Inst       V  St Fl
    step(1, 1, 0, 32'h0,         32'h00A0_0093, 32'h0000_0004, 32'h0000_0000, 32'h00A0_0093, 1, 0, 0);
    step(1, 1, 0, 32'h0,         32'h0010_8113, 32'h0000_0008, 32'h0000_0004, 32'h0010_8113, 1, 0, 0);
    // load-use stall at IF_PC=8
    step(0, 0, 0, 32'h0,         32'hDEAD_BEEF, 32'h0000_0008, 32'h0000_0004, 32'h0010_8113, 1, 1, 0);
    step(1, 1, 0, 32'h0,         32'h0020_8193, 32'h0000_000C, 32'h0000_0008, 32'h0020_8193, 1, 1, 0);
    step(1, 1, 0, 32'h0,         32'h0031_0213, 32'h0000_0010, 32'h0000_000C, 32'h0031_0213, 1, 1, 0);
    // redirect at IF_PC=16, low target bits dropped
    step(1, 1, 1, 32'h0000_0102, 32'h1111_1111, 32'h0000_0100, 32'h0000_0000, NOP,           0, 1, 1);
    step(1, 1, 0, 32'h0,         32'h0040_0293, 32'h0000_0104, 32'h0000_0100, 32'h0040_0293, 1, 1, 1);
    // PC advances while ID holds
    step(1, 0, 0, 32'h0,         32'h2222_2222, 32'h0000_0108, 32'h0000_0100, 32'h0040_0293, 1, 1, 1);
    // stall and redirect together: redirect wins, no stall counted
    step(0, 0, 1, 32'h0000_0200, 32'h3333_3333, 32'h0000_0200, 32'h0000_0000, NOP,           0, 1, 2);
    // PC held, ID loads
    step(0, 1, 0, 32'h0,         32'h0050_0313, 32'h0000_0200, 32'h0000_0200, 32'h0050_0313, 1, 2, 2);
    // back-to-back redirects, latest wins
    step(1, 1, 1, 32'h0000_0300, 32'h4444_4444, 32'h0000_0300, 32'h0000_0000, NOP,           0, 2, 3);
    step(1, 1, 1, 32'h0000_0403, 32'h5555_5555, 32'h0000_0400, 32'h0000_0000, NOP,           0, 2, 4);
    // a held bubble stays invalid
    step(0, 0, 0, 32'h0,         32'h6666_6666, 32'h0000_0400, 32'h0000_0000, NOP,           0, 3, 4);
    step(1, 1, 0, 32'h0,         32'h0060_0393, 32'h0000_0404, 32'h0000_0400, 32'h0060_0393, 1, 3, 4);
    // PC wrap
    step(1, 1, 1, 32'hFFFF_FFFF, 32'h7777_7777, 32'hFFFF_FFFC, 32'h0000_0000, NOP,           0, 3, 5);
    step(1, 1, 0, 32'h0,         32'h0070_0413, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0070_0413, 1, 3, 5);
    step(1, 1, 0, 32'h0,         32'h0080_0493, 32'h0000_0004, 32'h0000_0000, 32'h0080_0493, 1, 3, 5);

    // StallCount saturates at 4'hF
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 32'h0, 32'h8888_8888, 32'h0000_0004, 32'h0000_0000, 32'h0080_0493, 1,
           (4 + i > 15) ? 15 : 4 + i, 5);
    end
    // FlushCount saturates at 4'hF
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 1, 32'h0000_0500, 32'h9999_9999, 32'h0000_0500, 32'h0000_0000, NOP, 0,
           15, (6 + i > 15) ? 15 : 6 + i);
    end
    step(0, 0, 0, 32'h0, 32'hAAAA_AAAA, 32'h0000_0500, 32'h0000_0000, NOP, 0, 15, 15);

    // asynchronous reset between edges during a stall
    pcen = 1'b0; ifid_en = 1'b0; pcsrc = 1'b0;
    #2 rst = 1'b1;
    #1;
    r.if_pc = 32'h0; r.id_pc = 32'h0; r.id_inst = NOP; r.vld = 1'b0;
    r.stall = 0; r.flush = 0;
    chk_all("rst_async", r);
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 0, 32'h0, 32'h0090_0513, 32'h0000_0004, 32'h0000_0000, 32'h0090_0513, 1, 0, 0);
    step(0, 0, 0, 32'h0, 32'hBBBB_BBBB, 32'h0000_0004, 32'h0000_0000, 32'h0090_0513, 1, 1, 0);

    for (int i = 0; i < 5 && q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_frontend.md
Name: fetch_frontend

Overview:
- Front end of the 5-stage RISC-V pipeline. Contains the PC register, the IF/ID pipeline register and branch-redirect/flush handling.
- Consumes the stall enables produced by the load-use hazard detector (PCen, IF_IDen) and the taken-branch redirect from EX.
- Keeps saturating stall and flush performance counters for debug readout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID on flush or reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCen  in  1  1 = PC may advance; 0 = hold PC (load-use stall).
- IF_IDen  in  1  1 = IF/ID register loads; 0 = hold contents.
- EX_PCSrc  in  1  1 = branch/jump taken in EX this cycle.
- EX_Target  in  32  redirect target from EX.
- IMem_Inst  in  32  instruction read combinationally from IMem at IF_PC.
- IF_PC  out  32  current fetch address, drives IMem.
- ID_PC  out  32  PC of the instruction in ID.
- ID_Inst  out  32  instruction in ID.
- ID_Valid  out  1  1 = ID holds a real fetched instruction; 0 = bubble.
- StallCount  out  CNT_W  cycles stalled by PCen=0 with no redirect.
- FlushCount  out  CNT_W  number of redirect cycles.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high. All state is in flops updated on the rising edge of clk.
- Reset values, immediate on rst assertion:
  - IF_PC=RESET_PC, ID_PC=0, ID_Inst=NOP_INST, ID_Valid=0.
  - StallCount=0, FlushCount=0.
- First edge after rst deasserts behaves as a normal cycle.
- PC update, evaluated in priority order each edge:
  1. EX_PCSrc=1: IF_PC <= {EX_Target[31:2],2'b00}. PCen is ignored; redirect overrides stall.
  2. Else PCen=1: IF_PC <= IF_PC+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  3. Else: IF_PC holds.
- IF/ID update, evaluated in priority order each edge:
  1. EX_PCSrc=1: flush. ID_Inst<=NOP_INST, ID_PC<=0, ID_Valid<=0. IF_IDen is ignored.
  2. Else IF_IDen=1: ID_Inst<=IMem_Inst, ID_PC<=IF_PC, ID_Valid<=1.
  3. Else: all IF/ID fields hold, including ID_Valid.
- Redirect latency:
  - Target appears on IF_PC one cycle after EX_PCSrc.
  - The target instruction reaches ID two cycles after EX_PCSrc.
  - The cycle between them shows ID_Valid=0.
- Back-to-back redirects: each cycle with EX_PCSrc=1 re-flushes and reloads the PC; the latest target wins.
- PCen and IF_IDen are independent. PCen=1 with IF_IDen=0 is legal: the PC advances while ID holds. No consistency check is performed.
- StallCount: increments on an edge where EX_PCSrc=0 and PCen=0. Saturates at all-ones and never wraps.
- FlushCount: increments on an edge where EX_PCSrc=1. Saturates at all-ones and never wraps.
- Reset mid-stall or mid-redirect discards all in-flight state and clears both counters.
- No combinational path from any input to any output. IMem_Inst is sampled only at the edge.

Decomposition:
- Shared pipeline package holds:
  - NOP_INST constant (32'h0000_0013);
  - default RESET_PC;
  - instruction width constant (32).
- One sub-module: sat_counter.
  - Parameter: width.
  - Ports: clk, rst, inc, count.
  - Holds at all-ones.
  - Instantiated twice, for StallCount and FlushCount.

Test Plan:
- Reset and free run: rst pulse with PCen=IF_IDen=1, EX_PCSrc=0, IMem returning 32'h00A00093 → IF_PC goes 0,4,8,…. First edge after reset gives ID_PC=0, ID_Inst=00A00093, ID_Valid=1. Counters stay 0.
- Load-use stall: at IF_PC=8, drive PCen=IF_IDen=0 for 1 cycle → IF_PC holds at 8, ID_PC/ID_Inst hold, StallCount=1. The next cycle resumes to IF_PC=12.
- Redirect: at IF_PC=16, EX_PCSrc=1 with EX_Target=32'h0000_0102 → IF_PC=0x100 next cycle, ID_Inst=NOP_INST, ID_Valid=0, FlushCount=1. The following edge gives ID_PC=0x100 and ID_Valid=1.
- Simultaneous stall and redirect: PCen=IF_IDen=0 with EX_PCSrc=1, target 0x200 → IF_PC=0x200, ID flushed, StallCount unchanged, FlushCount increments.
- Wrap and saturation: force IF_PC=32'hFFFF_FFFC via redirect, then PCen=1 → IF_PC=0. With CNT_W=4, hold PCen=0 for 20 cycles → StallCount=4'hF.
- Async reset mid-stall: assert rst between edges during a stall → outputs take their reset values immediately without waiting for a clock edge. The counters read 0.
